// File: rtl/div_stage_if.sv
// div_stage_if: start/busy/done handshake, operand bus and divider connection for div_stage
interface div_stage_if;
    logic        start;
    logic        signed_op;
    logic [31:0] rs_a;
    logic [31:0] rs_b;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic        busy;
    logic        done;
    logic [31:0] lo_out;
    logic        dz;
    modport master (
        output start, signed_op, rs_a, rs_b, div_quotient,
        input  div_dividend, div_divisor, busy, done, lo_out, dz
    );
    modport slave (
        input  start, signed_op, rs_a, rs_b, div_quotient,
        output div_dividend, div_divisor, busy, done, lo_out, dz
    );
endinterface

// File: rtl/div_stage.sv
// div_stage: multicycle sequencer and sign conditioning around a combinational unsigned divider.
// Optional divide-by-zero trap enabled by defining DIV_ZERO_TRAP_EN.
module div_stage #(
    parameter int unsigned DIV_CYCLES = 4
) (
    input logic         clock,
    input logic         reset,
    div_stage_if.slave  bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_dividend, r_divisor, r_lo;
    logic        r_neg, r_zero, r_done, r_dz;
    logic        w_accept, w_finish, w_trap, w_zero;
    function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
        return (s && x[31]) ? -x : x;
    endfunction
    always_comb begin
        w_accept = (r_state == IDLE) && bus.start;
        w_finish = (r_state == WAIT) && (r_cnt == 4'd1);
        w_zero   = (bus.rs_b == 32'd0);
`ifdef DIV_ZERO_TRAP_EN
        w_trap   = w_accept && w_zero;
`else
        w_trap   = 1'b0;
`endif
        w_next   = w_trap ? IDLE : w_accept ? WAIT : w_finish ? IDLE : r_state;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_neg      <= 1'b0;
            r_zero     <= 1'b0;
            r_done     <= 1'b0;
            r_dz       <= 1'b0;
            r_lo       <= 32'd0;
            r_dividend <= 32'd0;
            r_divisor  <= 32'd0;
        end else begin
            r_state <= w_next;
            r_done  <= w_finish || w_trap;
            r_dz    <= w_trap;
            if (w_accept) begin
                r_dividend <= mag(bus.rs_a, bus.signed_op);
                r_divisor  <= mag(bus.rs_b, bus.signed_op);
                r_neg      <= bus.signed_op & (bus.rs_a[31] ^ bus.rs_b[31]);
                r_zero     <= w_zero;
                r_cnt      <= 4'(DIV_CYCLES);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // untrapped divide-by-zero returns all ones regardless of sign
            if (w_finish)
                r_lo <= r_zero ? 32'hFFFF_FFFF : r_neg ? -bus.div_quotient : bus.div_quotient;
        end
    end
    assign bus.div_dividend = r_dividend;
    assign bus.div_divisor  = r_divisor;
    assign bus.busy         = (r_state == WAIT);
    assign bus.done         = r_done;
    assign bus.lo_out       = r_lo;
`ifdef DIV_ZERO_TRAP_EN
    assign bus.dz           = r_dz;
`else
    assign bus.dz           = 1'b0;
    logic w_unused_dz;
    assign w_unused_dz      = r_dz;
`endif
endmodule

// File: tb/tb_div_stage.sv
// tb_div_stage: randomized scoreboard bench for div_stage with an arithmetic reference model
module tb_div_stage;
    localparam int DC = 4;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;
    div_stage_if bus();
    div_stage #(.DIV_CYCLES(DC)) dut (.clock(clock), .reset(reset), .bus(bus));
    assign bus.div_quotient = (bus.div_divisor == 32'd0) ? 32'hFFFF_FFFF : bus.div_dividend / bus.div_divisor;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic        dz;
        int          cyc;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    logic [31:0] model_lo = 32'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("lo_out", bus.lo_out, e.lo);
                    chk("dz", {31'd0, bus.dz}, {31'd0, e.dz});
                    chk("div_dividend", bus.div_dividend, e.dvd);
                    chk("div_divisor", bus.div_divisor, e.dvs);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    function automatic logic [31:0] mag32(input longint v);
        return 32'(v < 0 ? -v : v);
    endfunction

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        longint sa, sb;
        bus.start = 1'b1;
        bus.rs_a = a;
        bus.rs_b = b;
        bus.signed_op = s;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        e.dvd = mag32(sa);
        e.dvs = mag32(sb);
        e.dz = 1'b0;
        e.cyc = cyc + DC + 1;
        busy_lo = cyc + 1;
        busy_hi = cyc + DC;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_TRAP_EN
            e.dz = 1'b1;
            e.cyc = cyc + 1;
            busy_hi = 0;
`else
            model_lo = 32'hFFFF_FFFF;
`endif
        end else begin
            model_lo = 32'(sa / sb);
        end
        e.lo = model_lo;
        q.push_back(e);
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got pending %0d expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_lo_out"}, bus.lo_out, 32'd0);
        chk({tag, "_dividend"}, bus.div_dividend, 32'd0);
        chk({tag, "_divisor"}, bus.div_divisor, 32'd0);
        chk({tag, "_flags"}, {29'd0, bus.busy, bus.done, bus.dz}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.signed_op = 1'b0;
        bus.rs_a = 32'd0;
        bus.rs_b = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;
        op(32'd100, 32'd7, 1'b0);                      wait_idle();
        op(32'hFFFF_FF9C, 32'd7, 1'b1);                wait_idle();
        op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);        wait_idle();
        op(32'd1234, 32'd0, 1'b1);                     wait_idle();
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);        wait_idle();
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);        wait_idle();
        op(32'hFFFF_FFFF, 32'd1, 1'b0);                wait_idle();
        // start pulsed mid-operation must be ignored
        op(32'd900, 32'd9, 1'b0);
        @(posedge clock); #1;
        bus.start = 1'b1; bus.rs_a = 32'd5; bus.rs_b = 32'd0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (6) @(posedge clock);
        #1;
        // back-to-back: new start in the done cycle
        op(32'd77, 32'd7, 1'b0);
        for (int n = 0; n < 20 && !bus.done; n++) begin @(posedge clock); #1; end
        op(32'hFFFF_FFB3, 32'd7, 1'b1);
        wait_idle();
        // reset in cycle 2 of WAIT discards the operation
        op(32'd1000, 32'd3, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        q.delete();
        busy_hi = 0;
        model_lo = 32'd0;
        @(posedge clock); #1;
        reset = 1'b0;
        check_zero("midreset");
        repeat (8) @(posedge clock);
        #1;
        op(32'd50, 32'd5, 1'b0);                       wait_idle();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            int m;
            a = $urandom;
            m = $urandom_range(0, 7);
            b = (m == 0) ? 32'd0 : (m < 3) ? 32'($urandom_range(1, 20)) :
                (m == 3) ? 32'hFFFF_FFFF : (m == 4) ? 32'(-$urandom_range(1, 20)) : $urandom;
            op(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                for (int n = 0; n < 20 && !bus.done; n++) begin @(posedge clock); #1; end
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 2)) @(posedge clock);
                #1;
            end
        end
        wait_idle();
        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_stage.md
# div_stage

Sequencing and sign-conditioning stage wrapped around the combinational 32-bit unsigned restoring divider (`divide`). It takes operands from the register-read stage and converts signed operands to magnitudes. It drives the divider with registered, stable operands for a fixed multicycle window, then samples the quotient, applies sign correction and latches the result into the LO register feeding writeback. It gives the datapath a start/busy/done handshake, so the divider's long combinational path is never timed as single-cycle.

## Interface
- `DIV_CYCLES`, default 4: number of clock cycles the divider operands are held before the quotient is sampled; legal range 1..15.

- `clock`  in  1  : sole clock, rising edge.
- `reset`  in  1  : synchronous, active-high reset.
- `start`  in  1  : request; accepted only in IDLE.
- `signed_op`  in  1  : 1 = two's-complement divide, 0 = unsigned.
- `rs_a`  in  32  : dividend from register read.
- `rs_b`  in  32  : divisor from register read.
- `div_dividend`  out  32  : registered magnitude to divider `dividend`.
- `div_divisor`  out  32  : registered magnitude to divider `divisor`.
- `div_quotient`  in  32  : unsigned quotient from divider.
- `busy`  out  1  : high while in WAIT.
- `done`  out  1  : one-cycle pulse; `lo_out`/`dz` valid.
- `lo_out`  out  32  : signed/unsigned quotient register (LO).
- `dz`  out  1  : divide-by-zero flag; constant 0 when `DIV_ZERO_TRAP_EN` is not defined.

## Operation
- States:
  - IDLE: waiting for `start`.
  - WAIT: down-counter running.
- IDLE, `start`=1, on the clock edge:
  - Capture `div_dividend` = |rs_a| if `signed_op` and rs_a[31], else rs_a. Capture `div_divisor` the same way from `rs_b`.
  - Register `neg` = `signed_op` & (rs_a[31] ^ rs_b[31]).
  - Load counter = `DIV_CYCLES`, then go to WAIT.
- Magnitude uses 32-bit two's-complement negate. For 0x80000000 the magnitude stays 0x80000000, which is correct as unsigned.
- WAIT: the counter decrements each cycle.
- WAIT, counter = 1, on the clock edge:
  - `lo_out` = `neg` ? −div_quotient (32-bit wrap) : div_quotient.
  - `done` ← 1, then go to IDLE.
- Quotient truncates toward zero. No remainder is produced.
- −2^31 / −1 gives `neg`=0 and `lo_out`=0x80000000 (overflow wraps, no flag).
- `start` while in WAIT is ignored; no queueing.
- `div_dividend` and `div_divisor` are held constant for the whole of WAIT and keep their last values in IDLE.
- `lo_out` changes only on completion (or reset). It holds its value between operations.
- `reset` at any cycle:
  - State IDLE, counter 0, `neg` 0.
  - `busy`, `done`, `dz` = 0.
  - `lo_out`, `div_dividend`, `div_divisor` = 0.
  - `reset` has priority over `start`. An operation in flight is discarded and produces no `done`.

## Timing
- `start` is high in cycle 0. Then:
  - `busy`=1 in cycles 1..DIV_CYCLES.
  - `done`=1 and the new `lo_out` appear in cycle DIV_CYCLES+1, with `busy`=0.
- Latency is DIV_CYCLES+1 cycles from `start` to `done`. With DIV_CYCLES=1: `busy` for one cycle, `done` in cycle 2.
- `done` is high for exactly one cycle.
- A new `start` in the `done` cycle is accepted (back-to-back). Throughput is one divide per DIV_CYCLES+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `DIV_ZERO_TRAP_EN` defined:
  - `start` with rs_b = 0 skips WAIT.
  - Next cycle: `done`=1, `dz`=1 (one-cycle pulse with `done`), `busy` stays 0, `lo_out` unchanged.
  - `div_dividend` and `div_divisor` are still captured.
- `DIV_ZERO_TRAP_EN` undefined:
  - Divide-by-zero takes the normal WAIT latency.
  - `lo_out` is forced to 0xFFFFFFFF regardless of sign and `neg`.
  - `dz` is tied to 0.

## Test plan
- Unsigned, DIV_CYCLES=4: rs_a=100, rs_b=7, `signed_op`=0 -> `busy` cycles 1-4; `done` in cycle 5; `lo_out`=14.
- Signed: rs_a=0xFFFFFF9C (−100), rs_b=7 -> `div_dividend`=100; `lo_out`=0xFFFFFFF2 (−14). Then rs_a=−100, rs_b=−7 -> `lo_out`=14.
- Overflow: `signed_op`=1, rs_a=0x80000000, rs_b=0xFFFFFFFF -> `div_divisor`=1; `lo_out`=0x80000000; `dz`=0.
- Divide by zero, rs_b=0:
  - With macro: `done` and `dz` in cycle 1; `lo_out` keeps its prior value 14.
  - Without macro: `done` in cycle 5; `lo_out`=0xFFFFFFFF; `dz`=0.
- Handshake:
  - `start` pulsed in cycle 2 of WAIT -> ignored, single `done`.
  - New `start` in the `done` cycle -> second result after a further 5 cycles.
- Reset in cycle 2 of WAIT -> next cycle all outputs 0, no `done`. A subsequent 50/5 request gives `lo_out`=10.
